// File: rtl/visua_scheduler_if.sv
// Request/display bundle between image requesters and the visua scheduler.
interface visua_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int CODE_W  = 4
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*CODE_W-1:0] req_code;
    logic                      frame_done;
    logic [CODE_W-1:0]         visua;
    logic                      visua_update;
    logic [NUM_REQ-1:0]        grant;
    logic                      locked;

    modport master (
        output req_valid, req_code, frame_done,
        input  visua, visua_update, grant, locked
    );

    modport slave (
        input  req_valid, req_code, frame_done,
        output visua, visua_update, grant, locked
    );
endinterface

// File: rtl/visua_scheduler.sv
// Frame-synchronous arbiter choosing which requester's image code drives the display.
//
// state  | meaning
// SHOW0  | showing IDLE (0), waiting for an eligible request on a frame gap
// HOLD   | showing the grantee's image; hold/rotate/drop rules apply
// LOCKED | death image latched, left only by reset
module visua_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int CODE_W        = 4,
    parameter int MIN_FRAMES    = 8,
    parameter int ROTATE_FRAMES = 32,
    parameter int DEATH_CODE    = 13
) (
    input  logic clk_out,
    input  logic rst,
    visua_scheduler_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(ROTATE_FRAMES + 1);
    localparam logic [CODE_W-1:0] DEATH    = CODE_W'(DEATH_CODE);
    localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(13);

    typedef enum logic [1:0] {SHOW0, HOLD, LOCKED} state_t;

    state_t             state;
    logic [CNT_W-1:0]   frame_cnt;
    logic [PTR_W-1:0]   rr_ptr;
    logic               fd_q;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] cand;
    logic               death_any;
    logic               pick_any;
    logic [PTR_W-1:0]   pick_idx;
    logic [CODE_W-1:0]  pick_code;
    logic [CODE_W-1:0]  owner_code;
    logic               owner_elig;
    logic               fd_rise;
    logic               cnt_min;
    logic               cnt_rot;

    function automatic logic [CODE_W-1:0] code_of(input int idx);
        return bus.req_code[idx*CODE_W +: CODE_W];
    endfunction

    always_comb begin
        elig      = '0;
        death_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && code_of(i) != '0 && code_of(i) <= MAX_CODE) begin
                elig[i] = 1'b1;
                if (code_of(i) == DEATH)
                    death_any = 1'b1;
            end
        end
    end

    // Round-robin search starts after rr_ptr; in HOLD rr_ptr is the grantee and is excluded.
    always_comb begin
        cand = elig;
        if (state == HOLD)
            cand[rr_ptr] = 1'b0;
        pick_any = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!pick_any && cand[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick_any = 1'b1;
                pick_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign pick_code  = code_of(int'(pick_idx));
    assign owner_code = code_of(int'(rr_ptr));
    assign owner_elig = elig[rr_ptr];
    assign fd_rise    = bus.frame_done & ~fd_q;
    assign cnt_min    = frame_cnt >= CNT_W'(MIN_FRAMES);
    assign cnt_rot    = frame_cnt == CNT_W'(ROTATE_FRAMES);

    always_ff @(posedge clk_out) begin
        if (!rst) begin
            state            <= SHOW0;
            frame_cnt        <= '0;
            rr_ptr           <= '0;
            fd_q             <= 1'b0;
            bus.visua        <= '0;
            bus.visua_update <= 1'b0;
            bus.grant        <= '0;
            bus.locked       <= 1'b0;
        end else begin
            fd_q             <= bus.frame_done;
            bus.visua_update <= 1'b0;
            if (state == HOLD && fd_rise && frame_cnt < CNT_W'(ROTATE_FRAMES))
                frame_cnt <= frame_cnt + 1'b1;

            case (state)
                SHOW0: begin
                    if (bus.frame_done) begin
                        if (death_any) begin
                            state            <= LOCKED;
                            bus.visua        <= DEATH;
                            bus.visua_update <= 1'b1;
                            bus.grant        <= '0;
                            bus.locked       <= 1'b1;
                        end else if (pick_any) begin
                            state            <= HOLD;
                            rr_ptr           <= pick_idx;
                            frame_cnt        <= '0;
                            bus.visua        <= pick_code;
                            bus.visua_update <= 1'b1;
                            bus.grant        <= NUM_REQ'(1) << pick_idx;
                        end
                    end
                end

                HOLD: begin
                    if (bus.frame_done) begin
                        if (death_any) begin
                            state            <= LOCKED;
                            bus.visua        <= DEATH;
                            bus.visua_update <= 1'b1;
                            bus.grant        <= '0;
                            bus.locked       <= 1'b1;
                        end else if (cnt_min && !owner_elig) begin
                            frame_cnt <= '0;
                            if (pick_any) begin
                                rr_ptr           <= pick_idx;
                                bus.visua        <= pick_code;
                                bus.visua_update <= (pick_code != bus.visua);
                                bus.grant        <= NUM_REQ'(1) << pick_idx;
                            end else begin
                                state            <= SHOW0;
                                bus.visua        <= '0;
                                bus.visua_update <= 1'b1;
                                bus.grant        <= '0;
                            end
                        end else if (cnt_min && owner_code != bus.visua) begin
                            frame_cnt        <= '0;
                            bus.visua        <= owner_code;
                            bus.visua_update <= 1'b1;
                        end else if (cnt_rot && pick_any) begin
                            frame_cnt        <= '0;
                            rr_ptr           <= pick_idx;
                            bus.visua        <= pick_code;
                            bus.visua_update <= (pick_code != bus.visua);
                            bus.grant        <= NUM_REQ'(1) << pick_idx;
                        end
                    end
                end

                LOCKED: begin
                    bus.visua  <= DEATH;
                    bus.grant  <= '0;
                    bus.locked <= 1'b1;
                end

                default: begin
                    state     <= SHOW0;
                    bus.visua <= '0;
                    bus.grant <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_visua_scheduler.sv
// Directed bench for visua_scheduler: idle, first grant, drop, rotation, death lock, reset.
module tb_visua_scheduler;
    logic clk_out = 1'b0;
    logic rst     = 1'b0;
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   upd_cnt = 0;

    visua_scheduler_if #(.NUM_REQ(4), .CODE_W(4)) bus ();

    visua_scheduler #(
        .NUM_REQ(4), .CODE_W(4), .MIN_FRAMES(8), .ROTATE_FRAMES(32), .DEATH_CODE(13)
    ) dut (
        .clk_out (clk_out),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_out = ~clk_out;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk_out);
            #1;
            if (bus.visua_update) upd_cnt++;
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [3:0] c);
        bus.req_valid[i]       = v;
        bus.req_code[i*4 +: 4] = c;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            bus.frame_done = 1'b0;
            cyc(2);
            bus.frame_done = 1'b1;
            cyc(2);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        upd_cnt = 0;
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_code   = '0;
        bus.frame_done = 1'b1;

        // 1: idle after reset, ineligible codes ignored
        cyc(2);
        chk("rst_visua", int'(bus.visua), 0);
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_update", int'(bus.visua_update), 0);
        rst = 1'b1;
        cyc(100);
        chk("idle_updates", upd_cnt, 0);
        set_req(0, 1, 4'd14);
        set_req(3, 1, 4'd0);
        set_req(2, 1, 4'd15);
        cyc(20);
        chk("inelig_visua", int'(bus.visua), 0);
        chk("inelig_updates", upd_cnt, 0);

        // 2: first grant waits for frame_done
        bus.req_valid = '0; bus.req_code = '0;
        bus.frame_done = 1'b0;
        do_reset();
        set_req(0, 1, 4'd3);
        cyc(50);
        chk("wait_fd_visua", int'(bus.visua), 0);
        chk("wait_fd_updates", upd_cnt, 0);
        bus.frame_done = 1'b1;
        cyc(1);
        chk("grant0_visua", int'(bus.visua), 3);
        chk("grant0_grant", int'(bus.grant), 1);
        chk("grant0_pulse", int'(bus.visua_update), 1);
        cyc(1);
        chk("grant0_pulse_end", int'(bus.visua_update), 0);
        chk("grant0_pulses", upd_cnt, 1);

        // 3: grantee drop honoured only after MIN_FRAMES
        bus.req_valid = '0; bus.req_code = '0;
        do_reset();
        set_req(0, 1, 4'd1);
        cyc(1);
        chk("drop_grant_visua", int'(bus.visua), 1);
        frames(3);
        set_req(0, 0, 4'd1);
        frames(4);
        chk("drop_hold_visua", int'(bus.visua), 1);
        chk("drop_hold_grant", int'(bus.grant), 1);
        frames(1);
        chk("drop_idle_visua", int'(bus.visua), 0);
        chk("drop_idle_grant", int'(bus.grant), 0);
        chk("drop_pulses", upd_cnt, 2);

        // 4: round-robin rotation every ROTATE_FRAMES
        bus.req_valid = '0; bus.req_code = '0;
        do_reset();
        set_req(0, 1, 4'd2);
        cyc(1);
        chk("rot_init_grant", int'(bus.grant), 1);
        set_req(2, 1, 4'd5);
        frames(31);
        chk("rot_pre_grant", int'(bus.grant), 1);
        chk("rot_pre_visua", int'(bus.visua), 2);
        frames(1);
        chk("rot1_grant", int'(bus.grant), 4);
        chk("rot1_visua", int'(bus.visua), 5);
        frames(31);
        chk("rot2_pre_grant", int'(bus.grant), 4);
        frames(1);
        chk("rot2_grant", int'(bus.grant), 1);
        chk("rot2_visua", int'(bus.visua), 2);

        // 5: death code locks regardless of hold time
        bus.req_valid = '0; bus.req_code = '0;
        do_reset();
        set_req(1, 1, 4'd7);
        cyc(1);
        chk("death_pre_grant", int'(bus.grant), 2);
        frames(1);
        bus.frame_done = 1'b0;
        set_req(3, 1, 4'd13);
        cyc(2);
        chk("death_wait_visua", int'(bus.visua), 7);
        chk("death_wait_locked", int'(bus.locked), 0);
        bus.frame_done = 1'b1;
        cyc(1);
        chk("death_visua", int'(bus.visua), 13);
        chk("death_locked", int'(bus.locked), 1);
        chk("death_grant", int'(bus.grant), 0);
        chk("death_pulse", int'(bus.visua_update), 1);
        set_req(3, 0, 4'd0);
        set_req(0, 1, 4'd5);
        set_req(2, 1, 4'd9);
        frames(40);
        chk("locked_visua", int'(bus.visua), 13);
        chk("locked_grant", int'(bus.grant), 0);
        chk("locked_stay", int'(bus.locked), 1);
        do_reset();
        chk("unlock_locked", int'(bus.locked), 0);
        chk("unlock_visua", int'(bus.visua), 0);

        // 6: reset in HOLD restarts round-robin from 0
        bus.req_valid = '0; bus.req_code = '0;
        do_reset();
        set_req(1, 1, 4'd4);
        cyc(1);
        chk("hrst_pre_grant", int'(bus.grant), 2);
        set_req(2, 1, 4'd6);
        frames(2);
        rst = 1'b0;
        cyc(1);
        chk("hrst_visua", int'(bus.visua), 0);
        chk("hrst_grant", int'(bus.grant), 0);
        chk("hrst_update", int'(bus.visua_update), 0);
        rst = 1'b1;
        cyc(1);
        chk("hrst_regrant", int'(bus.grant), 2);
        chk("hrst_revisua", int'(bus.visua), 4);

        // code change by grantee takes effect after MIN_FRAMES
        set_req(1, 1, 4'd9);
        frames(7);
        chk("chg_hold_visua", int'(bus.visua), 4);
        frames(1);
        chk("chg_visua", int'(bus.visua), 9);
        chk("chg_grant", int'(bus.grant), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
